// File: rtl/imm_ext_pipe_pkg.sv
// Shared CPU package: immediate-extension mode encodings and mode width.
package imm_ext_pipe_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_ZERO = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SIGN = 3'd1;
  localparam logic [MODE_W-1:0] MODE_HIGH = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHL2 = 3'd3;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Input/output handshake bundle of the immediate-extension pipe.
// valid/ready: a beat transfers on a rising clk edge where both valid and ready are 1;
// once valid is raised by the producer, its payload is held until that transfer.
interface imm_ext_pipe_if
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [MODE_W-1:0] in_mode;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_err
  );

endinterface

// File: rtl/imm_ext_core.sv
// Pure combinational immediate extension; illegal modes fall back to zero-extension with err.
module imm_ext_core
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]   in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  ext_data,
  output logic              err
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = {{(OUT_W-IN_W){1'b0}}, in_data};
  assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    ext_data = zext;
    err      = 1'b0;
    case (in_mode)
      MODE_ZERO: ext_data = zext;
      MODE_SIGN: ext_data = sext;
      MODE_HIGH: ext_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      MODE_SHL2: ext_data = {sext[OUT_W-3:0], 2'b00};
      default:   err      = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// One-cycle immediate-extension stage with a main register and a skid register.
// in_ready is registered and equals "skid register empty".
module imm_ext_pipe
  import imm_ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  imm_ext_pipe_if.slave bus
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_data  (bus.in_data),
    .in_mode  (bus.in_mode),
    .ext_data (ext_data),
    .err      (ext_err)
  );

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_err_q,   main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;
  logic             in_ready_q,   in_ready_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = main_valid_q & bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // Main is free this edge: the older skid entry always goes first.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
        main_tag_d   = bus.in_tag;
        main_err_d   = ext_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_tag_d   = bus.in_tag;
      skid_err_d   = ext_err;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;
  assign bus.out_err   = main_err_q;

endmodule
